// File: rtl/sm_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_dmem_ctrl_if
// Brief    : schoolMIPS data-memory request/response bundle (core <-> memory)
// Revision : 1.0
// ============================================================================
interface sm_dmem_ctrl_if;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic        dmValid;
    logic        dmReady;
    logic [31:0] dmRData;
    logic        dmErr;

    modport master (
        output dmAddr, dmWe, dmWData, dmValid,
        input  dmReady, dmRData, dmErr
    );

    modport slave (
        input  dmAddr, dmWe, dmWData, dmValid,
        output dmReady, dmRData, dmErr
    );
endinterface
`default_nettype wire

// File: rtl/sm_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sm_dmem_ctrl
// Brief    : Word RAM behind the schoolMIPS data port with programmable stalls
// Revision : 1.0
// ============================================================================
module sm_dmem_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sm_dmem_ctrl_if.slave              bus,
    output logic [7:0]                 errCount,
    input  wire logic [ADDR_WIDTH-1:0] dbgAddr,
    output logic [31:0]                dbgData
);
    localparam int         c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] c_RD_N  = 4'(READ_WAIT);
    localparam logic [3:0] c_WR_N  = 4'(WRITE_WAIT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ill_q, ill_d;
    logic [7:0]            errcnt_q;
    logic [31:0]           mem_q [0:c_DEPTH-1];

    logic                  w_ill_live;
    logic [ADDR_WIDTH-1:0] w_idx_live;
    logic [3:0]            w_n;
    logic                  w_complete;
    logic                  w_ready;
    logic [ADDR_WIDTH-1:0] w_sel_idx;
    logic                  w_sel_we;
    logic [31:0]           w_sel_wdata;
    logic                  w_sel_ill;

    assign w_ill_live = (|bus.dmAddr[1:0]) | (|bus.dmAddr[31:ADDR_WIDTH+2]);
    assign w_idx_live = bus.dmAddr[ADDR_WIDTH+1:2];
    assign w_n        = bus.dmWe ? c_WR_N : c_RD_N;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ill_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ill_q   <= ill_d;
            if (w_complete && w_sel_ill && errcnt_q != 8'hFF) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dmValid && w_n != 4'd0) begin
                    idx_d   = w_idx_live;
                    we_d    = bus.dmWe;
                    wdata_d = bus.dmWData;
                    ill_d   = w_ill_live;
                    cnt_d   = w_n - 4'd1;
                    state_d = (w_n == 4'd1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // Dropping dmValid mid-wait abandons the access silently.
                if (!bus.dmValid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_complete  = 1'b0;
        w_ready     = 1'b1;
        w_sel_idx   = idx_q;
        w_sel_we    = we_q;
        w_sel_wdata = wdata_q;
        w_sel_ill   = ill_q;
        case (state_q)
            S_IDLE: begin
                // Zero-wait accesses complete from the live request fields.
                w_sel_idx   = w_idx_live;
                w_sel_we    = bus.dmWe;
                w_sel_wdata = bus.dmWData;
                w_sel_ill   = w_ill_live;
                if (bus.dmValid) begin
                    if (w_n == 4'd0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_ready = 1'b0;
                    end
                end
            end
            S_WAIT:  w_ready = 1'b0;
            S_DONE:  w_complete = 1'b1;
            default: w_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_complete && w_sel_we && !w_sel_ill) begin
            mem_q[w_sel_idx] <= w_sel_wdata;
        end
    end

    assign bus.dmReady = w_ready;
    assign bus.dmRData = (w_complete && !w_sel_ill) ? mem_q[w_sel_idx] : 32'd0;
    assign bus.dmErr   = w_complete & w_sel_ill;
    assign errCount    = errcnt_q;
    assign dbgData     = mem_q[dbgAddr];
endmodule
`default_nettype wire

// File: tb/tb_sm_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_dmem_ctrl
// Brief    : Directed bench for sm_dmem_ctrl across three wait-state setups
// Revision : 1.0
// ============================================================================
module tb_sm_dmem_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] addr_v [3];
    logic        we_v   [3];
    logic [31:0] wd_v   [3];
    logic        val_v  [3];
    logic [5:0]  dbg_v  [3];
    logic        rdy_o  [3];
    logic [31:0] rd_o   [3];
    logic        err_o  [3];
    logic [7:0]  ecnt_o [3];
    logic [31:0] dbgd_o [3];

    sm_dmem_ctrl_if ifa ();
    sm_dmem_ctrl_if ifb ();
    sm_dmem_ctrl_if ifc ();

    assign ifa.dmAddr = addr_v[0]; assign ifa.dmWe = we_v[0];
    assign ifa.dmWData = wd_v[0];  assign ifa.dmValid = val_v[0];
    assign ifb.dmAddr = addr_v[1]; assign ifb.dmWe = we_v[1];
    assign ifb.dmWData = wd_v[1];  assign ifb.dmValid = val_v[1];
    assign ifc.dmAddr = addr_v[2]; assign ifc.dmWe = we_v[2];
    assign ifc.dmWData = wd_v[2];  assign ifc.dmValid = val_v[2];

    assign rdy_o[0] = ifa.dmReady; assign rd_o[0] = ifa.dmRData; assign err_o[0] = ifa.dmErr;
    assign rdy_o[1] = ifb.dmReady; assign rd_o[1] = ifb.dmRData; assign err_o[1] = ifb.dmErr;
    assign rdy_o[2] = ifc.dmReady; assign rd_o[2] = ifc.dmRData; assign err_o[2] = ifc.dmErr;

    sm_dmem_ctrl #(.ADDR_WIDTH(6), .READ_WAIT(2), .WRITE_WAIT(1)) u_a (
        .clk(clk), .rst(rst), .bus(ifa), .errCount(ecnt_o[0]),
        .dbgAddr(dbg_v[0]), .dbgData(dbgd_o[0])
    );
    sm_dmem_ctrl #(.ADDR_WIDTH(6), .READ_WAIT(0), .WRITE_WAIT(0)) u_b (
        .clk(clk), .rst(rst), .bus(ifb), .errCount(ecnt_o[1]),
        .dbgAddr(dbg_v[1]), .dbgData(dbgd_o[1])
    );
    sm_dmem_ctrl #(.ADDR_WIDTH(6), .READ_WAIT(5), .WRITE_WAIT(3)) u_c (
        .clk(clk), .rst(rst), .bus(ifc), .errCount(ecnt_o[2]),
        .dbgAddr(dbg_v[2]), .dbgData(dbgd_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge; returns 1ns after the completion edge.
    task automatic acc(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int chg_at, input logic [31:0] a2, input logic [31:0] wd2,
                       input int drop_at, output int stalls, output logic [31:0] rd,
                       output logic er);
        addr_v[d] = a; we_v[d] = we; wd_v[d] = wd; val_v[d] = 1'b1;
        stalls = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy_o[d]) begin
                rd = rd_o[d];
                er = err_o[d];
                tick();
                val_v[d] = 1'b0;
                return;
            end
            stalls++;
            tick();
            if (stalls == drop_at) begin
                val_v[d] = 1'b0;
                return;
            end
            if (stalls == chg_at) begin
                addr_v[d] = a2;
                wd_v[d]   = wd2;
            end
        end
        total++;
        bad++;
        $error("FAIL acc_timeout observed=%0d expected=<40", stalls);
        val_v[d] = 1'b0;
    endtask

    initial begin
        int          st;
        int          stsum;
        logic [31:0] rd;
        logic        er;
        logic [31:0] v;

        total = 0; bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = '0; we_v[i] = 1'b0; wd_v[i] = '0; val_v[i] = 1'b0; dbg_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(rdy_o[0]), 32'd1);
        chk("rst_rdata", rd_o[0], 32'd0);
        chk("rst_err", 32'(err_o[0]), 32'd0);
        chk("rst_errcnt", 32'(ecnt_o[0]), 32'd0);
        tick();

        // Default waits: write then read
        acc(0, 1'b1, 32'h10, 32'hDEADBEEF, -1, 0, 0, -1, st, rd, er);
        chk("A_wr_stall", 32'(st), 32'd1);
        chk("A_wr_err", 32'(er), 32'd0);
        acc(0, 1'b0, 32'h10, 32'h0, -1, 0, 0, -1, st, rd, er);
        chk("A_rd_stall", 32'(st), 32'd2);
        chk("A_rd_data", rd, 32'hDEADBEEF);
        dbg_v[0] = 6'd4; #1;
        chk("A_dbg4", dbgd_o[0], 32'hDEADBEEF);

        // Illegal accesses
        acc(0, 1'b1, 32'h0, 32'h11111111, -1, 0, 0, -1, st, rd, er);
        acc(0, 1'b1, 32'h102, 32'hBAD0BAD0, -1, 0, 0, -1, st, rd, er);
        chk("A_mis_err", 32'(er), 32'd1);
        chk("A_mis_stall", 32'(st), 32'd1);
        chk("A_mis_cnt", 32'(ecnt_o[0]), 32'd1);
        dbg_v[0] = 6'd0; #1;
        chk("A_mis_mem0", dbgd_o[0], 32'h11111111);
        acc(0, 1'b0, 32'h400, 32'h0, -1, 0, 0, -1, st, rd, er);
        chk("A_oor_rdata", rd, 32'd0);
        chk("A_oor_err", 32'(er), 32'd1);
        chk("A_oor_cnt", 32'(ecnt_o[0]), 32'd2);
        for (int k = 0; k < 300; k++) begin
            acc(0, k[0], 32'h400 + 32'(k), 32'h0, -1, 0, 0, -1, st, rd, er);
        end
        chk("A_sat_cnt", 32'(ecnt_o[0]), 32'd255);
        acc(0, 1'b0, 32'h10, 32'h0, -1, 0, 0, -1, st, rd, er);
        chk("A_post_err", 32'(er), 32'd0);
        chk("A_post_data", rd, 32'hDEADBEEF);

        // Zero waits: alternate writes and reads, two passes
        stsum = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 64; i++) begin
                v = 32'hC0DE0000 + 32'(i * 7) + 32'(p * 32'h00100000);
                acc(1, 1'b1, 32'(i * 4), v, -1, 0, 0, -1, st, rd, er);
                stsum += st;
                acc(1, 1'b0, 32'(i * 4), 32'h0, -1, 0, 0, -1, st, rd, er);
                stsum += st;
                chk("B_rd_data", rd, v);
            end
        end
        chk("B_no_stall", 32'(stsum), 32'd0);

        // Long waits: abort in wait cycle 3
        acc(2, 1'b1, 32'h0, 32'h5A5A5A5A, -1, 0, 0, -1, st, rd, er);
        chk("C_wr_stall", 32'(st), 32'd3);
        acc(2, 1'b0, 32'h0, 32'h0, -1, 0, 0, 3, st, rd, er);
        @(negedge clk);
        chk("C_abort_err", 32'(err_o[2]), 32'd0);
        tick();
        @(negedge clk);
        chk("C_abort_idle", 32'(rdy_o[2]), 32'd1);
        chk("C_abort_cnt", 32'(ecnt_o[2]), 32'd0);
        tick();
        acc(2, 1'b0, 32'h0, 32'h0, -1, 0, 0, -1, st, rd, er);
        chk("C_rd_stall", 32'(st), 32'd5);
        chk("C_rd_data", rd, 32'h5A5A5A5A);

        // Request fields changed mid-wait are ignored
        acc(2, 1'b1, 32'h24, 32'h0000AAAA, -1, 0, 0, -1, st, rd, er);
        acc(2, 1'b1, 32'h20, 32'h0000BBBB, 1, 32'h24, 32'h0000CCCC, -1, st, rd, er);
        dbg_v[2] = 6'd8; #1;
        chk("C_chg_idx8", dbgd_o[2], 32'h0000BBBB);
        dbg_v[2] = 6'd9; #1;
        chk("C_chg_idx9", dbgd_o[2], 32'h0000AAAA);
        acc(2, 1'b0, 32'h20, 32'h0, 2, 32'h24, 32'h0, -1, st, rd, er);
        chk("C_chg_rd", rd, 32'h0000BBBB);

        // Reset in the middle of a write's wait
        acc(2, 1'b1, 32'h08, 32'h12345678, -1, 0, 0, -1, st, rd, er);
        addr_v[2] = 32'h08; we_v[2] = 1'b1; wd_v[2] = 32'hBAD0BAD0; val_v[2] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        val_v[2] = 1'b0;
        dbg_v[2] = 6'd2;
        @(negedge clk);
        chk("C_rst_ready", 32'(rdy_o[2]), 32'd1);
        chk("C_rst_mem", dbgd_o[2], 32'h12345678);
        chk("A_rst_cnt", 32'(ecnt_o[0]), 32'd0);
        chk("C_rst_cnt", 32'(ecnt_o[2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sm_dmem_ctrl.md
# sm_dmem_ctrl

Data-memory controller that sits directly downstream of the schoolMIPS CPU core's data-memory port. It consumes the core's single-outstanding request (address, write enable, write data, valid) and answers with read data and a ready strobe. Configurable read and write wait states exercise the core's `dmReady` stall path. The block owns a word-organised RAM, flags illegal accesses and exposes a debug read port.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: word-index bits; RAM depth is 2^ADDR_WIDTH words.
- `READ_WAIT`, 2: stall cycles per read, 0..15.
- `WRITE_WAIT`, 1: stall cycles per write, 0..15.

Ports:
- `clk` input 1: clock; everything is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `dmAddr` input 32: byte address from the core.
- `dmWe` input 1: 1 = write, 0 = read; qualified by `dmValid`.
- `dmWData` input 32: write data.
- `dmValid` input 1: access request; held by the core until completion.
- `dmReady` output 1: high = no stall; completes the access when `dmValid` is high.
- `dmRData` output 32: read data, valid only in the completion cycle, 0 otherwise.
- `dmErr` output 1: one-cycle pulse in the completion cycle of an illegal access.
- `errCount` output 8: saturating count of illegal accesses.
- `dbgAddr` input ADDR_WIDTH: debug word index.
- `dbgData` output 32: asynchronous read of `mem[dbgAddr]`.

## Operation
- Illegal access: `dmAddr[1:0] != 0`, or any of `dmAddr[31:ADDR_WIDTH+2]` nonzero.
- Legal access: uses word index `dmAddr[ADDR_WIDTH+1:2]`.
- Wait count per access: N = `dmWe` ? WRITE_WAIT : READ_WAIT.
- The FSM has three states: IDLE, WAIT and DONE.
- IDLE, `dmValid`=0: `dmReady`=1.
- IDLE, `dmValid`=1, N=0: completes combinationally in the same cycle. `dmReady`=1; read data comes from the live address; a write commits at this edge.
- IDLE, `dmValid`=1, N>0:
  - `dmReady`=0.
  - Latch addr, we, wdata and the illegal flag.
  - Load the counter with N-1.
  - Go to DONE if N=1, otherwise go to WAIT.
- WAIT:
  - `dmReady`=0 and the counter decrements.
  - Go to DONE when the counter reaches 0.
  - If `dmValid`=0 (abort), go to IDLE; the write is discarded and no error is counted.
- DONE:
  - `dmReady`=1 and `dmRData`=`mem[latched idx]`.
  - A write commits at this edge.
  - Go to IDLE unconditionally. The next cycle's `dmValid` is a new request.
- Request inputs that change during WAIT or DONE are ignored; the latched values are used.
- Illegal access:
  - Completes with the normal latency.
  - The write is suppressed and `dmRData`=0.
  - `dmErr`=1 in the completion cycle.
  - `errCount` increments and saturates at 255.
- Read-during-write: reads return pre-edge contents. `dbgData` reflects a write from the cycle after the commit edge.
- RAM contents are not reset.

## Timing
- Reset values: state=IDLE, counter=0, `dmErr`=0, `errCount`=0, `dmRData`=0.
- `dmReady` is 1 after reset when `dmValid`=0.
- Reset mid-access: go to IDLE and drop the pending write; RAM is untouched.
- Latency: if the request first appears in cycle 0, `dmReady` rises in cycle N. The core stalls exactly N cycles.
- Back-to-back requests: a request presented in the cycle after DONE is accepted in IDLE with no bubble beyond its own N.
- `dmReady`, `dmRData` and `dmErr` are combinational from state, `dmValid` and `dmWe`. There is no path from `dmRData` to `dmReady`.
- Counter width is 4 bits. N=15 gives 15 stall cycles.

## Test plan
- Defaults. Write `0xDEADBEEF` to addr `0x10`, then read addr `0x10`:
  - Write: `dmReady` is low for 1 cycle.
  - Read: low for 2 cycles, and `dmRData`=`0xDEADBEEF` in the completion cycle.
  - `dbgData`@idx 4 = `0xDEADBEEF`.
- READ_WAIT=0, WRITE_WAIT=0. Alternate writes and reads over idx 0..63:
  - `dmReady` never drops.
  - Every read returns the last value written.
- Illegal accesses:
  - Write to `0x102` (misaligned): `dmErr` pulses at completion; mem[0] is unchanged.
  - Read of `0x400` (out of range): `dmRData`=0 and `errCount`=2.
  - 300 illegal accesses: `errCount` holds at 255.
- READ_WAIT=5. Drop `dmValid` in wait cycle 3:
  - Return to IDLE with no `dmErr`.
  - A subsequent read has the full 5-cycle latency.
- Assert `rst` during a write's WAIT:
  - RAM is unchanged.
  - Next cycle: state is IDLE, `dmReady`=1, `errCount`=0.
- Change `dmAddr`/`dmWData` during WAIT: the latched values are the ones written and read.
